// File: rtl/icache_direct_if.sv
// Fetch-side and fill-side signals of the direct-mapped instruction cache.
// The cache side uses the slave modport; the environment (datapath plus
// memory controller) uses the master modport.
interface icache_direct_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        icache_flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    modport master (
        output imemREN, imemaddr, icache_flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

    modport slave (
        input  imemREN, imemaddr, icache_flush, iwait, iload,
        output ihit, imemload, iREN, iaddr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// Hits are answered combinationally; a miss issues a single-word fill and
// waits for the controller to drop iwait. Flush clears every valid bit and
// abandons any fill in progress. Hit/miss counters saturate at 16'hFFFF.
module icache_direct #(
    parameter int FRAMES = 16
) (
    input logic            CLK,
    input logic            RST,
    icache_direct_if.slave bus
);
    localparam int IDX_W = $clog2(FRAMES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state;
    state_t            state_next;
    logic [FRAMES-1:0] valid;
    logic [TAG_W-1:0]  tags [FRAMES];
    logic [31:0]       data [FRAMES];
    logic [31:0]       miss_addr;
    logic [15:0]       hit_cnt;
    logic [15:0]       miss_cnt;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  miss_idx;
    logic [TAG_W-1:0]  miss_tag;
    logic              lookup_hit;
    logic              hit;
    logic              ren;
    logic              start_miss;
    logic              fill_done;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign idx        = bus.imemaddr[IDX_W+1:2];
    assign tag        = bus.imemaddr[31:IDX_W+2];
    assign miss_idx   = miss_addr[IDX_W+1:2];
    assign miss_tag   = miss_addr[31:IDX_W+2];
    assign lookup_hit = valid[idx] && (tags[idx] == tag);

    assign bus.ihit       = hit;
    assign bus.imemload   = data[idx];
    assign bus.iREN       = ren;
    assign bus.iaddr      = miss_addr;
    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;

    // Next-state and handshake decode; flush overrides hits, misses and fill completion.
    always_comb begin
        state_next = state;
        hit        = 1'b0;
        ren        = 1'b0;
        start_miss = 1'b0;
        fill_done  = 1'b0;
        case (state)
            IDLE: begin
                hit = bus.imemREN && lookup_hit && !bus.icache_flush;
                if (bus.imemREN && !lookup_hit && !bus.icache_flush) begin
                    start_miss = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                ren = 1'b1;
                if (bus.icache_flush) begin
                    state_next = IDLE;
                end else if (!bus.iwait) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, frame array, miss address and counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            valid     <= '0;
            tags      <= '{default: '0};
            data      <= '{default: '0};
            miss_addr <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            state <= state_next;
            if (bus.icache_flush) begin
                valid <= '0;
            end else if (fill_done) begin
                valid[miss_idx] <= 1'b1;
                tags[miss_idx]  <= miss_tag;
                data[miss_idx]  <= bus.iload;
            end
            if (start_miss) begin
                miss_addr <= {bus.imemaddr[31:2], 2'b00};
                miss_cnt  <= sat_inc(miss_cnt);
            end
            if (hit) begin
                hit_cnt <= sat_inc(hit_cnt);
            end
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed scenarios followed by random traffic,
// every cycle compared against a behavioural cache model.
module tb_icache_direct;
    localparam int FRAMES = 16;
    localparam int IDX_W  = $clog2(FRAMES);

    logic CLK = 1'b0;
    logic RST = 1'b1;

    icache_direct_if bus();

    icache_direct #(.FRAMES(FRAMES)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // staged stimulus, applied on the falling edge
    logic        s_req   = 1'b0;
    logic [31:0] s_addr  = '0;
    logic        s_flush = 1'b0;
    logic        s_wait  = 1'b1;
    logic [31:0] s_load  = '0;
    logic        s_rst   = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model: frame table plus a pending-fill flag
    bit          m_known = 1'b0;
    bit          m_busy  = 1'b0;
    logic [31:0] m_addr  = '0;
    int          m_hits  = 0;
    int          m_misses = 0;
    bit          m_valid [FRAMES];
    logic [31:0] m_tag   [FRAMES];
    logic [31:0] m_data  [FRAMES];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % FRAMES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / 32'(4 * FRAMES);
    endfunction

    function automatic bit model_present(input logic [31:0] a);
        return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    function automatic bit model_hit();
        return !m_busy && s_req && !s_flush && model_present(s_addr);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < FRAMES; k++) begin
            m_valid[k] = 1'b0;
            m_tag[k]   = '0;
            m_data[k]  = '0;
        end
        m_busy   = 1'b0;
        m_addr   = '0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_step();
        bit h;
        int k;
        h = model_hit();
        if (s_rst) begin
            model_clear();
            m_known = 1'b1;
        end else if (m_known) begin
            if (h) m_hits = (m_hits >= 65535) ? 65535 : m_hits + 1;
            if (s_flush) begin
                for (int j = 0; j < FRAMES; j++) m_valid[j] = 1'b0;
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (!s_wait) begin
                    k = idx_of(m_addr);
                    m_valid[k] = 1'b1;
                    m_tag[k]   = tag_of(m_addr);
                    m_data[k]  = s_load;
                    m_busy     = 1'b0;
                end
            end else if (s_req && !model_present(s_addr)) begin
                m_busy   = 1'b1;
                m_addr   = {s_addr[31:2], 2'b00};
                m_misses = (m_misses >= 65535) ? 65535 : m_misses + 1;
            end
        end
    endtask

    // one clock: apply inputs, compare outputs mid-cycle, advance the model
    task automatic tick();
        @(negedge CLK);
        RST              = s_rst;
        bus.imemREN      = s_req;
        bus.imemaddr     = s_addr;
        bus.icache_flush = s_flush;
        bus.iwait        = s_wait;
        bus.iload        = s_load;
        #1;
        if (m_known) begin
            check_val("ihit",       32'(bus.ihit),       32'(model_hit()));
            check_val("imemload",   bus.imemload,        m_data[idx_of(s_addr)]);
            check_val("iREN",       32'(bus.iREN),       32'(m_busy));
            check_val("iaddr",      bus.iaddr,           m_addr);
            check_val("hit_count",  32'(bus.hit_count),  32'(m_hits));
            check_val("miss_count", 32'(bus.miss_count), 32'(m_misses));
        end
        @(posedge CLK);
        model_step();
        #2;
    endtask

    task automatic set_in(input logic req, input logic [31:0] addr, input logic wt, input logic [31:0] ld);
        s_req  = req;
        s_addr = addr;
        s_wait = wt;
        s_load = ld;
    endtask

    task automatic fill(input logic [31:0] addr, input logic [31:0] ld);
        set_in(1'b1, addr, 1'b0, ld);
        tick();
        tick();
    endtask

    initial begin
        logic [31:0] a;

        // reset for two cycles, then idle
        s_rst = 1'b1;
        tick();
        tick();
        s_rst = 1'b0;
        set_in(1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        check_val("rst_iren",  32'(bus.iREN),       32'd0);
        check_val("rst_iaddr", bus.iaddr,           32'd0);
        check_val("rst_ihit",  32'(bus.ihit),       32'd0);
        check_val("rst_hitc",  32'(bus.hit_count),  32'd0);
        check_val("rst_missc", 32'(bus.miss_count), 32'd0);

        // cold miss, three wait cycles, then fill and hit
        set_in(1'b1, 32'h0000_0040, 1'b1, 32'h0);
        tick();
        check_val("cold_iren",  32'(bus.iREN), 32'd1);
        check_val("cold_iaddr", bus.iaddr,     32'h40);
        tick();
        tick();
        tick();
        check_val("cold_iaddr_hold", bus.iaddr, 32'h40);
        s_wait = 1'b0;
        s_load = 32'hDEAD_BEEF;
        tick();
        check_val("cold_ihit",  32'(bus.ihit),       32'd1);
        check_val("cold_load",  bus.imemload,        32'hDEAD_BEEF);
        check_val("cold_missc", 32'(bus.miss_count), 32'd1);
        check_val("cold_iren0", 32'(bus.iREN),       32'd0);
        s_wait = 1'b1;
        tick();
        tick();
        check_val("cold_hitc",  32'(bus.hit_count),  32'd2);

        // conflict: same index, different tag
        fill(32'h0000_0004, 32'h1111_1111);
        check_val("conf_first_load", bus.imemload, 32'h1111_1111);
        set_in(1'b1, 32'h0000_0044, 1'b0, 32'h2222_2222);
        tick();
        check_val("conf_iren",  32'(bus.iREN), 32'd1);
        check_val("conf_iaddr", bus.iaddr,     32'h44);
        tick();
        check_val("conf_load",  bus.imemload,  32'h2222_2222);
        set_in(1'b1, 32'h0000_0004, 1'b0, 32'h1111_1111);
        tick();
        check_val("conf_remiss_iren",  32'(bus.iREN), 32'd1);
        check_val("conf_remiss_iaddr", bus.iaddr,     32'h04);
        tick();

        // flush after two fills
        fill(32'h0000_0080, 32'h8080_8080);
        fill(32'h0000_0084, 32'h8484_8484);
        set_in(1'b1, 32'h0000_0080, 1'b1, 32'h0);
        tick();
        check_val("pre_flush_hit", 32'(bus.ihit), 32'd1);
        s_req   = 1'b0;
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        set_in(1'b1, 32'h0000_0080, 1'b0, 32'h8080_8080);
        tick();
        check_val("flush_miss80", bus.iaddr, 32'h80);
        tick();
        set_in(1'b1, 32'h0000_0084, 1'b0, 32'h8484_8484);
        tick();
        check_val("flush_miss84", bus.iaddr, 32'h84);
        tick();

        // flush coinciding with fill completion
        set_in(1'b1, 32'h0000_0100, 1'b1, 32'h0);
        tick();
        tick();
        s_wait  = 1'b0;
        s_load  = 32'hBAD0_BAD0;
        s_flush = 1'b1;
        tick();
        check_val("abort_iren", 32'(bus.iREN), 32'd0);
        check_val("abort_ihit", 32'(bus.ihit), 32'd0);
        s_flush = 1'b0;
        s_wait  = 1'b1;
        tick();
        check_val("abort_remiss", 32'(bus.iREN), 32'd1);
        s_wait = 1'b0;
        s_load = 32'h0100_0100;
        tick();

        // reset while a fill is outstanding
        set_in(1'b1, 32'h0000_0200, 1'b1, 32'h0);
        tick();
        tick();
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        check_val("mrst_iren",  32'(bus.iREN),       32'd0);
        check_val("mrst_hitc",  32'(bus.hit_count),  32'd0);
        check_val("mrst_missc", 32'(bus.miss_count), 32'd0);
        tick();
        check_val("mrst_remiss", bus.iaddr,           32'h200);
        check_val("mrst_missc1", 32'(bus.miss_count), 32'd1);
        s_wait = 1'b0;
        s_load = 32'h0200_0200;
        tick();

        // random traffic over a small address set so hits and conflicts recur
        for (int n = 0; n < 4000; n++) begin
            a = ($urandom_range(0, 3) << (IDX_W + 2)) | ($urandom_range(0, FRAMES - 1) << 2)
                | $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) a = a ^ 32'hF000_0000;
            s_req   = ($urandom_range(0, 9) < 8);
            s_addr  = a;
            s_flush = ($urandom_range(0, 39) == 0);
            s_wait  = ($urandom_range(0, 1) == 1);
            s_load  = $urandom;
            s_rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        s_rst   = 1'b0;
        s_flush = 1'b0;

        // hit counter saturation
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        fill(32'h0000_0300, 32'h3030_3030);
        set_in(1'b1, 32'h0000_0300, 1'b1, 32'h0);
        for (int n = 0; n < 70000; n++) tick();
        check_val("sat_hitc",  32'(bus.hit_count),  32'h0000_FFFF);
        check_val("sat_missc", 32'(bus.miss_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the datapath fetch port and the instruction side of the memory controller. It serves hits in the same cycle. On a miss it issues a single-word fill request on the controller's `iREN`/`iaddr` port and holds it until `iwait` drops. Flush and saturating hit/miss counters support pipeline invalidation and performance measurement.

## Interface
- `FRAMES`, default 16: number of one-word frames; must be a power of two, minimum 2. `IDX_W` = log2(`FRAMES`).
- `CLK`, input, 1 bit: the single clock; all state updates on the rising edge.
- `RST`, input, 1 bit: synchronous, active-high reset.
- `imemREN`, input, 1 bit: datapath fetch request.
- `imemaddr`, input, 32 bits: fetch byte address; bits [1:0] ignored.
- `icache_flush`, input, 1 bit: invalidate all frames; single-cycle pulse or held.
- `ihit`, output, 1 bit: `imemload` is valid this cycle for `imemaddr`.
- `imemload`, output, 32 bits: instruction word from the indexed frame.
- `iREN`, output, 1 bit: fill request to the memory controller.
- `iaddr`, output, 32 bits: fill word address, bits [1:0] = 0.
- `iwait`, input, 1 bit: controller busy; 0 means `iload` is valid this cycle.
- `iload`, input, 32 bits: fill data from the controller.
- `hit_count`, output, 16 bits: saturating count of hits.
- `miss_count`, output, 16 bits: saturating count of misses.

## Operation
Address split:
- index = `imemaddr`[`IDX_W`+1:2]
- tag = `imemaddr`[31:`IDX_W`+2]

Per frame: a valid bit, a tag, and a 32-bit data word.

States:
- IDLE
  - `ihit` = `imemREN` & valid[index] & (tag[index] == tag).
  - `iREN` = 0.
  - `imemREN` & !hit & !`icache_flush`: latch {`imemaddr`[31:2], 2'b00} into the miss address register, go to FILL, increment `miss_count`.
- FILL
  - `iREN` = 1; `iaddr` = miss address register; `ihit` = 0.
  - On `iwait` = 0: write `iload` and the miss tag into the frame at the miss index, set valid, go to IDLE.
  - Stay in FILL while `iwait` = 1.
  - The fill completes even if `imemREN` drops or `imemaddr` changes; the datapath normally holds the address while stalled.

General rules:
- `imemload` = data[index of the current `imemaddr`] at all times; it is meaningful only when `ihit` = 1.
- `iaddr` is always driven from the miss address register, including in IDLE.
- `icache_flush` has priority over everything except reset:
  - clears all valid bits;
  - forces IDLE, discarding any fill in progress, even one whose `iwait` = 0 arrives in the same cycle;
  - forces `ihit` = 0 in that cycle;
  - leaves the counters unchanged.
- Counters:
  - `hit_count` increments on every cycle with `ihit` = 1.
  - `miss_count` increments on each IDLE-to-FILL transition.
  - Both hold at 16'hFFFF once reached.

Reset (`RST` = 1 at a rising edge), including mid-fill:
- state = IDLE; all valid bits = 0; all tags and data = 0.
- miss address register = 0; counters = 0.
- Resulting outputs: `iREN` = 0, `iaddr` = 0, `ihit` = 0, `imemload` = 0, `hit_count` = 0, `miss_count` = 0.

## Timing
- Hit latency: 0 cycles. `ihit` and `imemload` are combinational from `imemaddr` and registered tag/data.
- Miss:
  - Detected in cycle N; `iREN` asserted from cycle N+1.
  - If `iwait` = 0 first in cycle N+1+W, the frame is written at the end of that cycle.
  - `ihit` = 1 in cycle N+2+W. Minimum miss penalty is 2 cycles, with W = 0.
- No request is issued in the cycle a fill completes; back-to-back misses are spaced by at least one IDLE cycle.
- `iREN` falls on the edge after `iwait` = 0, after a flush, or after `RST`.
- Same-index, different-tag fill overwrites the frame; there is no replacement choice.

## Test plan
- Reset:
  - Stimulus: assert `RST` for 2 cycles, then release with `imemREN` = 0.
  - Required: `iREN` = 0, `iaddr` = 0, `ihit` = 0, both counters = 0.
- Cold miss then hit:
  - Stimulus: `imemREN` = 1, `imemaddr` = 0x00000040; hold `iwait` = 1 for 3 cycles, then 0 with `iload` = 0xDEADBEEF.
  - Required: `iaddr` = 0x40 while `iREN` = 1; next cycle `ihit` = 1, `imemload` = 0xDEADBEEF; `miss_count` = 1.
  - `hit_count` increments once per `ihit` cycle.
- Conflict (`FRAMES` = 16):
  - Stimulus: fill 0x00000004, then access 0x00000044 (same index, different tag).
  - Required: miss with `iaddr` = 0x44; a re-access of 0x04 misses again.
- Flush:
  - Stimulus: after two fills, pulse `icache_flush`; separately, pulse it in the same cycle as `iwait` = 0 during a fill.
  - Required: the next access to both addresses misses; the aborted frame is not valid; `iREN` = 0 the cycle after the flush.
- Reset mid-fill:
  - Stimulus: assert `RST` while in FILL with `iwait` = 1.
  - Required: `iREN` = 0 and counters = 0 after the edge; the previously requested address misses afterwards.
- Saturation:
  - Stimulus: preload a hit and hold `imemREN` = 1 for 70000 cycles.
  - Required: `hit_count` stops at 0xFFFF.
